fc_argmax_collector: RTL and testbench

- Sits directly downstream of the fully-connected layer. Captures the BCK_CELL signed neuron outputs the FC layer writes out (we/addr/out), one per write.
- When the FC layer signals layer end, it scans the captured values sequentially and reports the index and value of the maximum, i.e. the network's classification result.
- It also flags malformed write streams.

---
 rtl/fc_argmax_collector.sv | 193 +++++++++++++++++++
 tb/tb_fc_argmax_collector.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fc_argmax_collector.sv
// fc_argmax_collector
// Captures the neuron outputs written by the fully-connected layer. On layer
// end it walks the captured entries one per cycle and reports the index and
// value of the largest one, which is the classification result. It also
// flags writes to out-of-range addresses and writes that arrive while no
// collection is open.
module fc_argmax_collector #(
    parameter int BCK_CELL = 10,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int IDX_W    = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        addr,
    input  logic signed [DATA_W-1:0] in_value,
    input  logic                     layer_end,
    output logic                     busy,
    output logic                     result_valid,
    output logic [IDX_W-1:0]         class_idx,
    output logic signed [DATA_W-1:0] max_value,
    output logic                     incomplete,
    output logic                     addr_err,
    output logic                     overrun
);

    // One extra count bit so the scan counter can reach BCK_CELL, which is
    // the cycle spent publishing the result.
    localparam int CNT_W = IDX_W + 1;
    localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_SCAN    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                     state_r;
    state_t                     next_state_s;
    logic signed [DATA_W-1:0]   buf_r [BCK_CELL];
    logic [BCK_CELL-1:0]        mask_r;
    logic [CNT_W-1:0]           scan_cnt_r;
    logic signed [DATA_W-1:0]   run_max_r;
    logic [IDX_W-1:0]           run_idx_r;
    logic                       busy_r;
    logic                       result_valid_r;
    logic [IDX_W-1:0]           class_idx_r;
    logic signed [DATA_W-1:0]   max_value_r;
    logic                       incomplete_r;
    logic                       addr_err_r;
    logic                       overrun_r;

    logic                       addr_ok_s;
    logic                       write_ok_s;
    logic                       scan_last_s;
    logic signed [DATA_W-1:0]   entry_s;
    logic                       entry_wr_s;
    logic                       hit_s;

    // A write lands in the buffer only while collecting and only when it is
    // in range; a simultaneous start wins and discards it.
    always_comb begin
        addr_ok_s   = (addr < ADDR_W'(BCK_CELL));
        write_ok_s  = (state_r == ST_COLLECT) && we && !start && addr_ok_s;
        scan_last_s = (scan_cnt_r == CNT_W'(BCK_CELL));
    end

    // Select the entry under the scan pointer; past the last entry nothing
    // matches, so the entry reads as unwritten and cannot win.
    always_comb begin
        entry_s    = MIN_VAL;
        entry_wr_s = 1'b0;
        for (int i = 0; i < BCK_CELL; i++) begin
            entry_s    = (scan_cnt_r == CNT_W'(i)) ? buf_r[i]  : entry_s;
            entry_wr_s = (scan_cnt_r == CNT_W'(i)) ? mask_r[i] : entry_wr_s;
        end
        // Strict signed compare keeps the lowest index on ties.
        hit_s = entry_wr_s && (entry_s > run_max_r);
    end

    // Next-state logic; start restarts collection from any state.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_COLLECT;
                else       next_state_s = ST_IDLE;
            end
            ST_COLLECT: begin
                if (start)          next_state_s = ST_COLLECT;
                else if (layer_end) next_state_s = ST_SCAN;
                else                next_state_s = ST_COLLECT;
            end
            ST_SCAN: begin
                if (start)            next_state_s = ST_COLLECT;
                else if (scan_last_s) next_state_s = ST_DONE;
                else                  next_state_s = ST_SCAN;
            end
            ST_DONE: begin
                if (start) next_state_s = ST_COLLECT;
                else       next_state_s = ST_DONE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= next_state_s;
    end

    // Neuron value storage; contents only matter where the mask bit is set.
    always_ff @(posedge clk) begin
        if (write_ok_s) begin
            for (int i = 0; i < BCK_CELL; i++) begin
                if (addr == ADDR_W'(i)) buf_r[i] <= in_value;
            end
        end
    end

    // Written mask, scan pointer, running maximum, result and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_r         <= '0;
            scan_cnt_r     <= '0;
            run_max_r      <= MIN_VAL;
            run_idx_r      <= '0;
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
            class_idx_r    <= '0;
            max_value_r    <= MIN_VAL;
            incomplete_r   <= 1'b0;
            addr_err_r     <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            result_valid_r <= 1'b0;
            busy_r         <= (next_state_s == ST_COLLECT) || (next_state_s == ST_SCAN);
            if (start) begin
                mask_r       <= '0;
                scan_cnt_r   <= '0;
                incomplete_r <= 1'b0;
                addr_err_r   <= 1'b0;
                overrun_r    <= 1'b0;
            end else begin
                if (we) begin
                    if (state_r == ST_COLLECT) begin
                        if (addr_ok_s) begin
                            for (int i = 0; i < BCK_CELL; i++) begin
                                if (addr == ADDR_W'(i)) mask_r[i] <= 1'b1;
                            end
                        end else begin
                            addr_err_r <= 1'b1;
                        end
                    end else begin
                        overrun_r <= 1'b1;
                    end
                end
                if ((state_r == ST_COLLECT) && layer_end) begin
                    scan_cnt_r <= '0;
                    run_max_r  <= MIN_VAL;
                    run_idx_r  <= '0;
                end
                if (state_r == ST_SCAN) begin
                    if (scan_last_s) begin
                        class_idx_r    <= run_idx_r;
                        max_value_r    <= run_max_r;
                        incomplete_r   <= ~&mask_r;
                        result_valid_r <= 1'b1;
                    end else begin
                        if (hit_s) begin
                            run_max_r <= entry_s;
                            run_idx_r <= scan_cnt_r[IDX_W-1:0];
                        end
                        scan_cnt_r <= scan_cnt_r + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign busy         = busy_r;
    assign result_valid = result_valid_r;
    assign class_idx    = class_idx_r;
    assign max_value    = max_value_r;
    assign incomplete   = incomplete_r;
    assign addr_err     = addr_err_r;
    assign overrun      = overrun_r;

endmodule

// File: tb/tb_fc_argmax_collector.sv
// Testbench for fc_argmax_collector: a table of full write sets with their
// expected argmax results, plus directed sequences for address errors,
// same-cycle layer end writes, overrun during scan and reset mid-scan.
module tb_fc_argmax_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        we;
    logic [15:0] addr;
    logic [15:0] in_value;
    logic        layer_end;
    logic        busy;
    logic        result_valid;
    logic [4:0]  class_idx;
    logic [15:0] max_value;
    logic        incomplete;
    logic        addr_err;
    logic        overrun;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [9:0]       wmask;
        logic [0:9][15:0] vals;
        logic [4:0]       exp_idx;
        logic [15:0]      exp_max;
        logic             exp_inc;
    } vec_t;

    vec_t tab [8];

    fc_argmax_collector #(
        .BCK_CELL(10), .DATA_W(16), .ADDR_W(16), .IDX_W(5)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .we(we), .addr(addr),
        .in_value(in_value), .layer_end(layer_end), .busy(busy),
        .result_valid(result_valid), .class_idx(class_idx),
        .max_value(max_value), .incomplete(incomplete),
        .addr_err(addr_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [9:0] m,
                                input int a0, input int a1, input int a2, input int a3, input int a4,
                                input int a5, input int a6, input int a7, input int a8, input int a9,
                                input int ei, input int em, input logic inc);
        vec_t v;
        int   a [10];
        a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8, a9};
        v.wmask = m;
        for (int i = 0; i < 10; i++) v.vals[i] = a[i][15:0];
        v.exp_idx = ei[4:0];
        v.exp_max = em[15:0];
        v.exp_inc = inc;
        return v;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        we       = 1'b1;
        addr     = a[15:0];
        in_value = d;
        tick();
        we       = 1'b0;
    endtask

    task automatic load(input vec_t v, input int last);
        for (int i = 0; i <= last; i++) begin
            if (v.wmask[i]) wr(i, v.vals[i]);
        end
    endtask

    // Waits for result_valid; 'already' ticks have elapsed since the layer_end edge.
    task automatic wait_result(input string tag, input int already,
                               input logic [4:0] ei, input logic [15:0] em, input logic inc);
        int cnt;
        bit seen;
        cnt  = already;
        seen = 1'b0;
        while (cnt < 40 && !seen) begin
            tick();
            cnt = cnt + 1;
            if (result_valid) seen = 1'b1;
        end
        chk({tag, " latency"}, cnt, 32'd11);
        chk({tag, " class_idx"}, {27'd0, class_idx}, {27'd0, ei});
        chk({tag, " max_value"}, {16'd0, max_value}, {16'd0, em});
        chk({tag, " incomplete"}, {31'd0, incomplete}, {31'd0, inc});
        tick();
        chk({tag, " pulse width"}, {31'd0, result_valid}, 32'd0);
        chk({tag, " busy done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic finish_scan(input string tag, input logic [4:0] ei,
                               input logic [15:0] em, input logic inc);
        layer_end = 1'b1;
        tick();
        layer_end = 1'b0;
        wait_result(tag, 0, ei, em, inc);
    endtask

    initial begin
        int rv_seen;
        tab[0] = mk(10'h3FF, 5, -3, 100, 7, 100, -250, 0, 99, 1, 2, 2, 100, 1'b0);
        tab[1] = mk(10'h3FF, -250, -247, -244, -241, -238, -235, -232, -229, -226, -223,
                    9, -223, 1'b0);
        tab[2] = mk(10'h048, 0, 0, 0, -40, 0, 0, -41, 0, 0, 0, 3, -40, 1'b1);
        tab[3] = mk(10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8000, 1'b1);
        tab[4] = mk(10'h3FF, -32768, -32768, -32768, -32768, -32768, -32768, -32768,
                    -32768, -32768, -32768, 0, 32'h8000, 1'b0);
        tab[5] = mk(10'h3FF, -32768, -32768, -32768, -32768, -32768, -1, -32768,
                    -32768, -32768, -32768, 5, 32'hFFFF, 1'b0);
        tab[6] = mk(10'h3FF, 32767, -5, -5, -5, -5, -5, -5, 32767, -5, -5, 0, 32767, 1'b0);
        tab[7] = mk(10'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, -32768, 0, 32'h8000, 1'b1);

        reset = 1'b1; start = 1'b0; we = 1'b0; addr = '0; in_value = '0; layer_end = 1'b0;
        repeat (3) tick();
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst result_valid", {31'd0, result_valid}, 32'd0);
        chk("rst class_idx", {27'd0, class_idx}, 32'd0);
        chk("rst max_value", {16'd0, max_value}, 32'h8000);
        chk("rst flags", {29'd0, incomplete, addr_err, overrun}, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle busy", {31'd0, busy}, 32'd0);

        // Table-driven result checks.
        for (int k = 0; k < 8; k++) begin
            pulse_start();
            chk($sformatf("vec%0d busy", k), {31'd0, busy}, 32'd1);
            load(tab[k], 9);
            finish_scan($sformatf("vec%0d", k), tab[k].exp_idx, tab[k].exp_max, tab[k].exp_inc);
        end

        // Out-of-range write at the boundary address and beyond.
        pulse_start();
        load(tab[0], 9);
        wr(10, 16'd30000);
        chk("addr_err set", {31'd0, addr_err}, 32'd1);
        wr(12, 16'd30001);
        finish_scan("addr_err", 5'd2, 16'd100, 1'b0);
        chk("addr_err sticky", {31'd0, addr_err}, 32'd1);
        chk("addr_err no overrun", {31'd0, overrun}, 32'd0);
        pulse_start();
        chk("addr_err cleared", {31'd0, addr_err}, 32'd0);

        // Write together with layer_end, then a stray write during scan.
        load(tab[0], 8);
        we = 1'b1; addr = 16'd9; in_value = 16'd500; layer_end = 1'b1;
        tick();
        we = 1'b0; layer_end = 1'b0;
        tick();
        wr(0, 16'd1000);
        chk("overrun set", {31'd0, overrun}, 32'd1);
        wait_result("same_cycle", 2, 5'd9, 16'd500, 1'b0);
        chk("overrun sticky", {31'd0, overrun}, 32'd1);

        // layer_end while DONE is ignored.
        layer_end = 1'b1;
        tick();
        layer_end = 1'b0;
        rv_seen = 0;
        repeat (15) begin
            tick();
            if (result_valid) rv_seen = rv_seen + 1;
        end
        chk("done layer_end ignored", rv_seen, 32'd0);

        // Restart from DONE keeps the old result visible.
        pulse_start();
        chk("restart class_idx held", {27'd0, class_idx}, 32'd9);
        chk("restart max_value held", {16'd0, max_value}, 32'd500);
        chk("restart overrun cleared", {31'd0, overrun}, 32'd0);

        // Reset four cycles into the scan.
        load(tab[0], 9);
        layer_end = 1'b1;
        tick();
        layer_end = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rv_seen = 0;
        repeat (15) begin
            if (result_valid) rv_seen = rv_seen + 1;
            tick();
        end
        chk("abort no result_valid", rv_seen, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort class_idx", {27'd0, class_idx}, 32'd0);
        chk("abort max_value", {16'd0, max_value}, 32'h8000);
        chk("abort flags", {29'd0, incomplete, addr_err, overrun}, 32'd0);
        pulse_start();
        load(tab[1], 9);
        finish_scan("after_abort", 5'd9, 16'hFF21, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
